sweep_ctrl: RTL and testbench
=============================

SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 SHALL provide parameter FW, default 10, width of the frequency tuning word driven to the NCO.
REQ-002 SHALL provide parameter PW, default 8, width of the phase offset word driven to the NCO.
REQ-003 SHALL provide parameter DW, default 16, width of the step-rate and dwell counters.
REQ-004 SHALL have port clk  in  1  single system clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port start  in  1  begin a sweep; sampled only in IDLE.
REQ-007 SHALL have port stop  in  1  abort the sweep; sampled in every non-IDLE state.
REQ-008 SHALL have port mode  in  2  sweep mode: 00 single up, 01 repeating sawtooth, 10 repeating triangle, 11 treated as 00.
REQ-009 SHALL have port f_start, f_stop, f_step  in  FW each  lower bound, upper bound and increment of the tuning word.
REQ-010 SHALL have port step_div  in  DW  number of extra cycles between frequency steps.
REQ-011 SHALL have port dwell  in  DW  number of extra cycles held at each end point.
REQ-012 SHALL have port phase_in  in  PW  NCO phase offset.
REQ-013 SHALL have port freq_word  out  FW  registered tuning word to the NCO.
REQ-014 SHALL have port phase_word  out  PW  registered phase offset to the NCO.
REQ-015 SHALL have port nco_en  out  1  NCO enable.
REQ-016 SHALL have port busy  out  1  high in every state except IDLE.
REQ-017 SHALL have port done  out  1  one-cycle pulse when a single sweep completes.

Function
REQ-018 SHALL implement five states: IDLE, UP, DWELL_HI, DOWN, DWELL_LO.
REQ-019 On a clock edge in IDLE with start=1 and stop=0, SHALL do all of the following on that edge: latch mode, f_start, f_stop, f_step, step_div, dwell and phase_in; load freq_word=f_start and phase_word=phase_in; clear the prescaler; set nco_en=1; enter UP.
REQ-020 Configuration input changes after the start edge SHALL have no effect until the next start.
REQ-021 In UP, the prescaler SHALL increment every cycle; on the edge where it equals step_div, SHALL clear the prescaler and step freq_word, giving one step every step_div+1 cycles.
REQ-022 An UP step SHALL compute freq_word+f_step in FW+1 bits, with no wrap. If the result is >= f_stop, freq_word SHALL become f_stop and the state SHALL become DWELL_HI with the dwell counter cleared; otherwise freq_word SHALL take the sum.
REQ-023 If f_stop <= f_start, or f_step == 0, the first UP step SHALL load f_stop and enter DWELL_HI.
REQ-024 In each dwell state, the dwell counter SHALL increment every cycle; the state SHALL be left on the edge where the counter equals dwell, giving dwell+1 cycles.
REQ-025 Leaving DWELL_HI in mode 00/11 SHALL enter IDLE, deassert nco_en and busy, and assert done for exactly one cycle; freq_word SHALL hold f_stop.
REQ-026 Leaving DWELL_HI in mode 01 SHALL load freq_word=f_start, clear the prescaler and re-enter UP.
REQ-027 Leaving DWELL_HI in mode 10 SHALL clear the prescaler and enter DOWN.
REQ-028 In DOWN, SHALL use the same prescaler timing as UP. A step SHALL subtract f_step without underflow; if the result is <= f_start, or would be negative, freq_word SHALL become f_start and the state SHALL become DWELL_LO. Leaving DWELL_LO SHALL clear the prescaler and enter UP.
REQ-029 stop=1 in any non-IDLE state SHALL enter IDLE on that edge with nco_en=0 and busy=0, hold freq_word and phase_word, and produce no done pulse.
REQ-030 If stop and start are both 1 in IDLE, stop SHALL win and the block SHALL remain in IDLE.
REQ-031 start while busy SHALL be ignored.
REQ-032 freq_word, phase_word, nco_en and busy SHALL change only on clock edges; done SHALL be a registered output.

Reset
REQ-033 When rst_n=0, regardless of clk, the block SHALL enter IDLE and clear freq_word, phase_word, nco_en, busy, done, the prescaler, the dwell counter and all latched configuration to 0.
REQ-034 Reset asserted mid-sweep SHALL take effect immediately with no done pulse; after rst_n deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-035 Single sweep: f_start=100, f_stop=130, f_step=10, step_div=3, dwell=2, mode=00, start at edge N -> freq_word=100 at N, 110 at N+4, 120 at N+8, 130 at N+12; done high for the cycle after N+15; nco_en=0 from N+15.
REQ-036 Saturation: f_start=100, f_stop=125, f_step=10 -> freq_word sequence 100, 110, 120, 125; never 130.
REQ-037 Triangle: mode=10, f_start=0, f_stop=20, f_step=10, step_div=0, dwell=0 -> freq_word cycles 0,10,20,20,10,0,0,10,... indefinitely; done never asserted.
REQ-038 Abort: stop pulsed during UP at freq_word=110 -> IDLE next edge, freq_word=110 held, nco_en=0, no done; start in the same cycle as stop in IDLE -> stays IDLE.
REQ-039 Degenerate settings: f_step=0 or f_stop=50 < f_start=100 -> freq_word jumps to f_stop at the first step and dwells.
REQ-040 Async reset: rst_n pulsed low between clock edges mid-dwell -> all outputs 0 immediately; a new start after release runs a clean sweep.

Source files
------------

// File: rtl/sweep_ctrl.sv
// Frequency sweep controller: walks an NCO tuning word between two bounds in
// single, sawtooth or triangle fashion with programmable step rate and end-point dwell.
module sweep_ctrl #(
  parameter int unsigned FW = 10,
  parameter int unsigned PW = 8,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic [1:0]    mode,
  input  logic [FW-1:0] f_start,
  input  logic [FW-1:0] f_stop,
  input  logic [FW-1:0] f_step,
  input  logic [DW-1:0] step_div,
  input  logic [DW-1:0] dwell,
  input  logic [PW-1:0] phase_in,
  output logic [FW-1:0] freq_word,
  output logic [PW-1:0] phase_word,
  output logic          nco_en,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    UP       = 3'd1,
    DWELL_HI = 3'd2,
    DOWN     = 3'd3,
    DWELL_LO = 3'd4
  } state_t;

  localparam logic [1:0] MODE_SAW = 2'b01;
  localparam logic [1:0] MODE_TRI = 2'b10;

  state_t        state_q, state_d;
  logic [FW-1:0] freq_q, freq_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          nco_en_q, nco_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] presc_q, presc_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [1:0]    mode_q, mode_d;
  logic [FW-1:0] f_start_q, f_start_d;
  logic [FW-1:0] f_stop_q, f_stop_d;
  logic [FW-1:0] f_step_q, f_step_d;
  logic [DW-1:0] step_div_q, step_div_d;
  logic [DW-1:0] dwell_q, dwell_d;

  logic [FW:0]   up_sum;
  logic [FW-1:0] dn_diff;
  logic          up_hit, dn_hit, step_tick, dwell_end;

  // Step arithmetic: up in FW+1 bits so the carry saturates, down guarded against borrow.
  always_comb begin
    up_sum    = {1'b0, freq_q} + {1'b0, f_step_q};
    dn_diff   = freq_q - f_step_q;
    up_hit    = (f_stop_q <= f_start_q) || (f_step_q == '0) || (up_sum >= {1'b0, f_stop_q});
    dn_hit    = (freq_q < f_step_q) || (dn_diff <= f_start_q);
    step_tick = (presc_q == step_div_q);
    dwell_end = (dcnt_q == dwell_q);
  end

  always_comb begin
    state_d    = state_q;
    freq_d     = freq_q;
    phase_d    = phase_q;
    nco_en_d   = nco_en_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    presc_d    = presc_q;
    dcnt_d     = dcnt_q;
    mode_d     = mode_q;
    f_start_d  = f_start_q;
    f_stop_d   = f_stop_q;
    f_step_d   = f_step_q;
    step_div_d = step_div_q;
    dwell_d    = dwell_q;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          mode_d     = mode;
          f_start_d  = f_start;
          f_stop_d   = f_stop;
          f_step_d   = f_step;
          step_div_d = step_div;
          dwell_d    = dwell;
          freq_d     = f_start;
          phase_d    = phase_in;
          presc_d    = '0;
          nco_en_d   = 1'b1;
          busy_d     = 1'b1;
          state_d    = UP;
        end
      end
      UP: begin
        if (step_tick) begin
          presc_d = '0;
          if (up_hit) begin
            freq_d  = f_stop_q;
            dcnt_d  = '0;
            state_d = DWELL_HI;
          end else begin
            freq_d = up_sum[FW-1:0];
          end
        end else begin
          presc_d = presc_q + DW'(1);
        end
      end
      DWELL_HI: begin
        if (dwell_end) begin
          case (mode_q)
            MODE_SAW: begin
              freq_d  = f_start_q;
              presc_d = '0;
              state_d = UP;
            end
            MODE_TRI: begin
              presc_d = '0;
              state_d = DOWN;
            end
            default: begin
              nco_en_d = 1'b0;
              busy_d   = 1'b0;
              done_d   = 1'b1;
              state_d  = IDLE;
            end
          endcase
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      DOWN: begin
        if (step_tick) begin
          presc_d = '0;
          if (dn_hit) begin
            freq_d  = f_start_q;
            dcnt_d  = '0;
            state_d = DWELL_LO;
          end else begin
            freq_d = dn_diff;
          end
        end else begin
          presc_d = presc_q + DW'(1);
        end
      end
      DWELL_LO: begin
        if (dwell_end) begin
          presc_d = '0;
          state_d = UP;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        nco_en_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase

    // Abort overrides any sweep activity; output words are frozen.
    if (state_q != IDLE && stop) begin
      state_d  = IDLE;
      freq_d   = freq_q;
      phase_d  = phase_q;
      nco_en_d = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      freq_q     <= '0;
      phase_q    <= '0;
      nco_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      presc_q    <= '0;
      dcnt_q     <= '0;
      mode_q     <= '0;
      f_start_q  <= '0;
      f_stop_q   <= '0;
      f_step_q   <= '0;
      step_div_q <= '0;
      dwell_q    <= '0;
    end else begin
      state_q    <= state_d;
      freq_q     <= freq_d;
      phase_q    <= phase_d;
      nco_en_q   <= nco_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      presc_q    <= presc_d;
      dcnt_q     <= dcnt_d;
      mode_q     <= mode_d;
      f_start_q  <= f_start_d;
      f_stop_q   <= f_stop_d;
      f_step_q   <= f_step_d;
      step_div_q <= step_div_d;
      dwell_q    <= dwell_d;
    end
  end

  assign freq_word  = freq_q;
  assign phase_word = phase_q;
  assign nco_en     = nco_en_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Scoreboard bench for sweep_ctrl: expected per-cycle outputs are queued when a
// sweep is launched and compared on each falling edge.
module tb_sweep_ctrl;

  localparam int unsigned FW = 10;
  localparam int unsigned PW = 8;
  localparam int unsigned DW = 16;

  typedef struct packed {
    logic [FW-1:0] f;
    logic [PW-1:0] p;
    logic          en;
    logic          busy;
    logic          done;
  } exp_t;

  logic          clk, rst_n, start, stop;
  logic [1:0]    mode;
  logic [FW-1:0] f_start, f_stop, f_step;
  logic [DW-1:0] step_div, dwell;
  logic [PW-1:0] phase_in;
  logic [FW-1:0] freq_word;
  logic [PW-1:0] phase_word;
  logic          nco_en, busy, done;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  int   tri_pat[6] = '{0, 10, 20, 20, 10, 0};
  int   saw_pat[3] = '{0, 10, 20};

  sweep_ctrl #(.FW(FW), .PW(PW), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .f_start    (f_start),
    .f_stop     (f_stop),
    .f_step     (f_step),
    .step_div   (step_div),
    .dwell      (dwell),
    .phase_in   (phase_in),
    .freq_word  (freq_word),
    .phase_word (phase_word),
    .nco_en     (nco_en),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic push(input int f, input int en, input int bsy, input int dn, input int ph);
    exp_t e;
    e.f    = FW'(f);
    e.p    = PW'(ph);
    e.en   = 1'(en);
    e.busy = 1'(bsy);
    e.done = 1'(dn);
    exp_q.push_back(e);
  endtask

  // Expected trace of a one-shot up sweep, from start edge through the cycle after done.
  task automatic push_single(input int fs, input int fe, input int st, input int sd,
                             input int dw, input int ph);
    int v;
    bit reached;
    v = fs;
    reached = 1'b0;
    repeat (sd + 1) push(v, 1, 1, 0, ph);
    while (!reached) begin
      if (fe <= fs || st == 0 || v + st >= fe) begin
        reached = 1'b1;
        repeat (dw + 1) push(fe, 1, 1, 0, ph);
      end else begin
        v = v + st;
        repeat (sd + 1) push(v, 1, 1, 0, ph);
      end
    end
    push(fe, 0, 0, 1, ph);
    push(fe, 0, 0, 0, ph);
  endtask

  task automatic drain_n(input int n);
    exp_t e;
    repeat (n) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check_eq("freq_word", 32'(freq_word), 32'(e.f));
        check_eq("phase_word", 32'(phase_word), 32'(e.p));
        check_eq("nco_en", 32'(nco_en), 32'(e.en));
        check_eq("busy", 32'(busy), 32'(e.busy));
        check_eq("done", 32'(done), 32'(e.done));
      end
    end
  endtask

  task automatic drain();
    drain_n(exp_q.size());
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_freq"}, 32'(freq_word), 32'd0);
    check_eq({tag, "_phase"}, 32'(phase_word), 32'd0);
    check_eq({tag, "_nco_en"}, 32'(nco_en), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // Launch on the next rising edge, then scramble configuration to prove it was latched.
  task automatic start_sweep(input logic [1:0] md, input int fs, input int fe, input int st,
                             input int sd, input int dw, input int ph);
    mode     = md;
    f_start  = FW'(fs);
    f_stop   = FW'(fe);
    f_step   = FW'(st);
    step_div = DW'(sd);
    dwell    = DW'(dw);
    phase_in = PW'(ph);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    mode     = 2'($urandom);
    f_start  = FW'($urandom);
    f_stop   = FW'($urandom);
    f_step   = FW'($urandom);
    step_div = DW'($urandom_range(0, 7));
    dwell    = DW'($urandom_range(0, 7));
    phase_in = PW'($urandom);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = '0;
    f_start = '0; f_stop = '0; f_step = '0; step_div = '0; dwell = '0; phase_in = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset_idle");

    // One-shot sweep; a start pulse while busy must be ignored.
    push_single(100, 130, 10, 3, 2, 8'h3C);
    start_sweep(2'b00, 100, 130, 10, 3, 2, 8'h3C);
    start = 1'b1;
    drain_n(6);
    start = 1'b0;
    drain();

    // Saturating last step, mode 11 behaves as one-shot.
    push_single(100, 125, 10, 1, 1, 8'h11);
    start_sweep(2'b11, 100, 125, 10, 1, 1, 8'h11);
    drain();

    // Triangle runs indefinitely until stopped.
    for (int k = 0; k < 18; k++) push(tri_pat[k % 6], 1, 1, 0, 8'h77);
    start_sweep(2'b10, 0, 20, 10, 0, 0, 8'h77);
    drain();
    stop = 1'b1;
    push(0, 0, 0, 0, 8'h77);
    push(0, 0, 0, 0, 8'h77);
    drain_n(1);
    stop = 1'b0;
    drain();

    // Sawtooth reloads f_start after each top dwell.
    for (int k = 0; k < 9; k++) push(saw_pat[k % 3], 1, 1, 0, 8'h5A);
    start_sweep(2'b01, 0, 20, 10, 0, 0, 8'h5A);
    drain();
    stop = 1'b1;
    push(20, 0, 0, 0, 8'h5A);
    push(20, 0, 0, 0, 8'h5A);
    drain_n(1);
    stop = 1'b0;
    drain();

    // Abort in UP at 110, then start+stop together in IDLE.
    repeat (4) push(100, 1, 1, 0, 8'h44);
    push(110, 1, 1, 0, 8'h44);
    start_sweep(2'b00, 100, 130, 10, 3, 2, 8'h44);
    drain();
    stop = 1'b1;
    push(110, 0, 0, 0, 8'h44);
    push(110, 0, 0, 0, 8'h44);
    drain_n(1);
    stop = 1'b0;
    drain();
    start = 1'b1;
    stop  = 1'b1;
    push(110, 0, 0, 0, 8'h44);
    push(110, 0, 0, 0, 8'h44);
    drain();
    start = 1'b0;
    stop  = 1'b0;

    // Degenerate: zero step, then stop below start.
    push_single(100, 130, 0, 1, 0, 8'h22);
    start_sweep(2'b00, 100, 130, 0, 1, 0, 8'h22);
    drain();
    push_single(100, 50, 10, 2, 1, 8'h33);
    start_sweep(2'b00, 100, 50, 10, 2, 1, 8'h33);
    drain();

    // Asynchronous reset mid-dwell, then a clean sweep.
    push_single(100, 130, 10, 3, 2, 8'h66);
    start_sweep(2'b00, 100, 130, 10, 3, 2, 8'h66);
    drain_n(14);
    exp_q.delete();
    check_eq("pre_reset_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("after_release");
    push_single(100, 125, 10, 1, 1, 8'h99);
    start_sweep(2'b00, 100, 125, 10, 1, 1, 8'h99);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
